// File: rtl/loader_pkg.sv
// Package for regfile_stream_loader: FSM state encoding, host-packet target codes and
// the number of data bytes carried by each regfile write packet.
package loader_pkg;

  // Loader FSM states. DONE is terminal until reset.
  typedef enum logic [2:0] {
    S_HDR     = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_DATA    = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  // Target field, taken from header bits [7:6].
  localparam logic [1:0] TGT_INEX  = 2'b00;
  localparam logic [1:0] TGT_STATE = 2'b01;
  localparam logic [1:0] TGT_START = 2'b10;
  localparam logic [1:0] TGT_RSVD  = 2'b11;

  // Data bytes per packet: ceil(32/8) for InexRecur, ceil(18/8) for state.
  localparam int INEX_NB  = 4;
  localparam int STATE_NB = 3;

endpackage

// File: rtl/regfile_stream_loader.sv
// regfile_stream_loader
//   Decodes a host byte stream (valid/ready) into random-write commands for
//   regfile_InexRecur and regfile_state, then raises is_start to launch the accelerator.
//
// Ports
//   clk, rst                   clock; synchronous active-high reset
//   in_valid, in_data, in_ready host byte stream; a byte transfers when in_valid & in_ready
//   ran_we/w_addr/w_data_InexRecur         write port of regfile_InexRecur
//   ran_we/w_addr/w_data_state_external    write port of regfile_state
//   is_start                   level, high from the START command until reset
//   err                        sticky, a reserved header was seen
//   wr_count                   number of regfile writes issued, saturating
//   dbg_state                  current FSM state (loader_pkg::state_e encoding)
//
// Handshake: in_ready depends only on the FSM state (never on in_valid); a byte is
// consumed on the rising edge where in_valid and in_ready are both high, and in_data
// must be stable while in_valid is high. Holding in_valid low simply stalls the FSM.
module regfile_stream_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int INEX_W  = 32,
  parameter int STATE_W = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               ran_we_InexRecur,
  output logic [ADDR_W-1:0]  ran_w_addr_InexRecur,
  output logic [INEX_W-1:0]  ran_w_data_InexRecur,
  output logic               ran_we_state_external,
  output logic [ADDR_W-1:0]  ran_w_addr_state_external,
  output logic [STATE_W-1:0] ran_w_data_state_external,
  output logic               is_start,
  output logic               err,
  output logic [15:0]        wr_count,
  output logic [2:0]         dbg_state
);

  state_e               state_q, state_d;
  logic                 is_inex_q, is_inex_d;   // current packet targets InexRecur
  logic [7:0]           addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;         // assembled packet address
  logic [1:0]           cnt_q, cnt_d;           // data bytes still to come, minus one
  logic [31:0]          shift_q, shift_d;       // byte-shift data assembler
  logic                 err_q, err_d;
  logic [15:0]          wr_count_q, wr_count_d;
  logic [ADDR_W-1:0]    inex_addr_q, inex_addr_d;
  logic [INEX_W-1:0]    inex_data_q, inex_data_d;
  logic [ADDR_W-1:0]    st_addr_q, st_addr_d;
  logic [STATE_W-1:0]   st_data_q, st_data_d;
  logic                 accept;

  always_comb begin
    state_d     = state_q;
    is_inex_d   = is_inex_q;
    addr_hi_d   = addr_hi_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    err_d       = err_q;
    wr_count_d  = wr_count_q;
    inex_addr_d = inex_addr_q;
    inex_data_d = inex_data_q;
    st_addr_d   = st_addr_q;
    st_data_d   = st_data_q;

    in_ready = (state_q == S_HDR) || (state_q == S_ADDR_HI) ||
               (state_q == S_ADDR_LO) || (state_q == S_DATA);
    accept   = in_valid && in_ready;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          case (in_data[7:6])
            TGT_INEX: begin
              is_inex_d = 1'b1;
              state_d   = S_ADDR_HI;
            end
            TGT_STATE: begin
              is_inex_d = 1'b0;
              state_d   = S_ADDR_HI;
            end
            TGT_START: state_d = S_DONE;
            default:   err_d   = 1'b1;  // reserved: drop the byte, stay in HDR
          endcase
        end
      end
      S_ADDR_HI: begin
        if (accept) begin
          addr_hi_d = in_data;
          state_d   = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (accept) begin
          // Upper address bits beyond ADDR_W are dropped here.
          addr_d  = ADDR_W'({addr_hi_q, in_data});
          cnt_d   = is_inex_q ? 2'(INEX_NB - 1) : 2'(STATE_NB - 1);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          shift_d = 32'({shift_q, in_data});
          if (cnt_q == 2'd0) begin
            // Last byte: latch the target's address/data so they are valid during
            // the WRITE-cycle strobe and then hold until that port's next write.
            state_d = S_WRITE;
            if (is_inex_q) begin
              inex_addr_d = addr_q;
              inex_data_d = shift_d[INEX_W-1:0];
            end else begin
              st_addr_d = addr_q;
              st_data_d = shift_d[STATE_W-1:0];
            end
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      S_WRITE: begin
        if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
        state_d = S_HDR;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR;
      is_inex_q   <= 1'b0;
      addr_hi_q   <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      err_q       <= 1'b0;
      wr_count_q  <= '0;
      inex_addr_q <= '0;
      inex_data_q <= '0;
      st_addr_q   <= '0;
      st_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      is_inex_q   <= is_inex_d;
      addr_hi_q   <= addr_hi_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      err_q       <= err_d;
      wr_count_q  <= wr_count_d;
      inex_addr_q <= inex_addr_d;
      inex_data_q <= inex_data_d;
      st_addr_q   <= st_addr_d;
      st_data_q   <= st_data_d;
    end
  end

  // Strobes come straight from the WRITE state; rst masks them so a reset landing
  // in the WRITE cycle never lets a write through.
  assign ran_we_InexRecur          = (state_q == S_WRITE) && is_inex_q && !rst;
  assign ran_we_state_external     = (state_q == S_WRITE) && !is_inex_q && !rst;
  assign ran_w_addr_InexRecur      = inex_addr_q;
  assign ran_w_data_InexRecur      = inex_data_q;
  assign ran_w_addr_state_external = st_addr_q;
  assign ran_w_data_state_external = st_data_q;
  assign is_start                  = (state_q == S_DONE);
  assign err                       = err_q;
  assign wr_count                  = wr_count_q;
  assign dbg_state                 = state_q;

endmodule

// File: tb/tb_regfile_stream_loader.sv
// Testbench for regfile_stream_loader. Writes observed on either regfile port are
// captured as {target, addr, data} records and compared against records computed
// from the packet contents (address modulo 4096, data modulo 2^width).
module tb_regfile_stream_loader;

  localparam int REC_W = 45;  // {is_state, addr[11:0], data[31:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ran_we_InexRecur;
  logic [11:0] ran_w_addr_InexRecur;
  logic [31:0] ran_w_data_InexRecur;
  logic        ran_we_state_external;
  logic [11:0] ran_w_addr_state_external;
  logic [17:0] ran_w_data_state_external;
  logic        is_start;
  logic        err;
  logic [15:0] wr_count;
  logic [2:0]  dbg_state;

  regfile_stream_loader dut (
    .clk                       (clk),
    .rst                       (rst),
    .in_valid                  (in_valid),
    .in_data                   (in_data),
    .in_ready                  (in_ready),
    .ran_we_InexRecur          (ran_we_InexRecur),
    .ran_w_addr_InexRecur      (ran_w_addr_InexRecur),
    .ran_w_data_InexRecur      (ran_w_data_InexRecur),
    .ran_we_state_external     (ran_we_state_external),
    .ran_w_addr_state_external (ran_w_addr_state_external),
    .ran_w_data_state_external (ran_w_data_state_external),
    .is_start                  (is_start),
    .err                       (err),
    .wr_count                  (wr_count),
    .dbg_state                 (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int exp_wr = 0;  // model write count (saturation not reachable in this run)

  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] obs_q[$];
  int unsigned      obs_cyc[$];

  // Capture every strobe mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (ran_we_InexRecur) begin
      obs_q.push_back({1'b0, ran_w_addr_InexRecur, ran_w_data_InexRecur});
      obs_cyc.push_back(cyc);
    end
    if (ran_we_state_external) begin
      obs_q.push_back({1'b1, ran_w_addr_state_external, 14'd0, ran_w_data_state_external});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    exp_wr = 0;
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int waited;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_byte_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sends one write packet and records the write it must produce.
  task automatic send_packet(input logic is_state, input logic [15:0] addr16,
                             input logic [31:0] data, input int max_gap);
    logic [31:0] exp_data;
    logic [11:0] exp_addr;
    send_byte({1'b0, is_state, 6'($urandom)}, max_gap);
    send_byte(addr16[15:8], max_gap);
    send_byte(addr16[7:0], max_gap);
    if (!is_state) send_byte(data[31:24], max_gap);
    send_byte(data[23:16], max_gap);
    send_byte(data[15:8], max_gap);
    send_byte(data[7:0], max_gap);
    exp_addr = 12'(addr16 % 16'd4096);
    exp_data = is_state ? (data % 32'h40000) : data;
    exp_q.push_back({is_state, exp_addr, exp_data});
    exp_wr++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    apply_reset(2);
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if ({ran_we_InexRecur, ran_we_state_external} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b want 00", {ran_we_InexRecur, ran_we_state_external}); end
    n_vec++; if (is_start !== 1'b0) begin n_err++; $display("FAIL reset_is_start: got %b want 0", is_start); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_vec++; if (wr_count !== 16'd0) begin n_err++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
    n_vec++; if ({ran_w_addr_InexRecur, ran_w_data_InexRecur, ran_w_addr_state_external, ran_w_data_state_external} !== '0) begin
      n_err++; $display("FAIL reset_addr_data: got %h/%h/%h/%h want 0", ran_w_addr_InexRecur, ran_w_data_InexRecur, ran_w_addr_state_external, ran_w_data_state_external);
    end
    @(posedge clk); #1;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_inex_write;
    logic [7:0] bytes [7] = '{8'h00, 8'h00, 8'h05, 8'h02, 8'h01, 8'h00, 8'h06};
    for (int i = 0; i < 7; i++) send_byte(bytes[i], 0);
    exp_wr++;
    // Strobe must be high in exactly the cycle after the last byte is taken.
    @(negedge clk);
    n_vec++; if (ran_we_InexRecur !== 1'b1 || ran_we_state_external !== 1'b0) begin n_err++; $display("FAIL inex_strobe_latency: got we=%b/%b want 1/0", ran_we_InexRecur, ran_we_state_external); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL inex_ready_in_write: got %b want 0", in_ready); end
    @(negedge clk);
    n_vec++; if (ran_we_InexRecur !== 1'b0) begin n_err++; $display("FAIL inex_strobe_width: got %b want 0", ran_we_InexRecur); end
    n_vec++; if (ran_w_addr_InexRecur !== 12'h005) begin n_err++; $display("FAIL inex_addr: got %h want 005", ran_w_addr_InexRecur); end
    n_vec++; if (ran_w_data_InexRecur !== 32'h02010006) begin n_err++; $display("FAIL inex_data: got %h want 02010006", ran_w_data_InexRecur); end
    n_vec++; if (wr_count !== 16'(exp_wr)) begin n_err++; $display("FAIL inex_wr_count: got %0d want %0d", wr_count, exp_wr); end
    n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL inex_strobe_count: got %0d want 1", obs_q.size()); end
    @(posedge clk); #1;
    obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_state_write;
    logic [7:0] bytes [6] = '{8'h40, 8'h0F, 8'hFF, 8'h03, 8'hFF, 8'hFF};
    for (int i = 0; i < 6; i++) send_byte(bytes[i], 1);
    exp_wr++;
    @(negedge clk);
    n_vec++; if (ran_we_state_external !== 1'b1 || ran_we_InexRecur !== 1'b0) begin n_err++; $display("FAIL state_strobe: got we=%b/%b want 0/1", ran_we_InexRecur, ran_we_state_external); end
    n_vec++; if (ran_w_addr_state_external !== 12'hFFF) begin n_err++; $display("FAIL state_addr: got %h want fff", ran_w_addr_state_external); end
    n_vec++; if (ran_w_data_state_external !== 18'h3FFFF) begin n_err++; $display("FAIL state_data: got %h want 3ffff", ran_w_data_state_external); end
    // The InexRecur port keeps the previous write's values.
    n_vec++; if (ran_w_addr_InexRecur !== 12'h005 || ran_w_data_InexRecur !== 32'h02010006) begin
      n_err++; $display("FAIL inex_hold: got %h/%h want 005/02010006", ran_w_addr_InexRecur, ran_w_data_InexRecur);
    end
    idle(2);
    n_vec++; if (wr_count !== 16'(exp_wr)) begin n_err++; $display("FAIL state_wr_count: got %0d want %0d", wr_count, exp_wr); end
    n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL state_strobe_count: got %0d want 1", obs_q.size()); end
    obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_stall;
    send_packet(1'b0, 16'h0005, 32'h02010006, 4);
    idle(4);
    n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL stall_strobe_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_vec++; if (obs_q[0] !== exp_q[0]) begin n_err++; $display("FAIL stall_write: got %h want %h", obs_q[0], exp_q[0]); end
    end
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_random_packets;
    logic [REC_W-1:0] e;
    logic [REC_W-1:0] o;
    for (int i = 0; i < 24; i++)
      send_packet(1'($urandom_range(1, 0)), 16'($urandom), $urandom, 2);
    idle(3);
    n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++; if (o !== e) begin n_err++; $display("FAIL random_write: got %h want %h", o, e); end
    end
    n_vec++; if (wr_count !== 16'(exp_wr)) begin n_err++; $display("FAIL random_wr_count: got %0d want %0d", wr_count, exp_wr); end
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) send_packet(1'b0, 16'($urandom), $urandom, 0);
    idle(3);
    n_vec++; if (obs_cyc.size() != 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", obs_cyc.size()); end
    if (obs_cyc.size() == 3) begin
      for (int i = 1; i < 3; i++) begin
        n_vec++; if (obs_cyc[i] - obs_cyc[i-1] != 8) begin n_err++; $display("FAIL b2b_spacing: got %0d cycles want 8", obs_cyc[i] - obs_cyc[i-1]); end
      end
      for (int i = 0; i < 3; i++) begin
        n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_write: got %h want %h", obs_q[i], exp_q[i]); end
      end
    end
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_packet;
    logic [7:0] part [6] = '{8'h00, 8'h01, 8'h23, 8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 6; i++) send_byte(part[i], 0);
    apply_reset(1);
    idle(2);
    n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rst_mid_no_strobe: got %0d writes want 0", obs_q.size()); end
    n_vec++; if (wr_count !== 16'd0) begin n_err++; $display("FAIL rst_mid_wr_count: got %0d want 0", wr_count); end
    send_packet(1'b0, 16'hA123, 32'hDEADBEEF, 1);
    idle(2);
    n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL rst_fresh_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_vec++; if (obs_q[0] !== exp_q[0]) begin n_err++; $display("FAIL rst_fresh_write: got %h want %h", obs_q[0], exp_q[0]); end
    end
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    // Reset landing in the WRITE cycle suppresses the strobe.
    for (int i = 0; i < 6; i++) send_byte(part[i], 0);
    send_byte(8'hDD, 0);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (ran_we_InexRecur !== 1'b0) begin n_err++; $display("FAIL rst_in_write_strobe: got %b want 0", ran_we_InexRecur); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_wr = 0;
    idle(2);
    n_vec++; if (obs_q.size() != 0 || wr_count !== 16'd0) begin n_err++; $display("FAIL rst_in_write_effect: got %0d writes cnt %0d want 0/0", obs_q.size(), wr_count); end
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_reserved_and_start;
    int ready_seen;
    send_packet(1'b1, 16'h0123, 32'h0002ABCD, 0);
    idle(2);
    send_byte(8'hC0 | 8'($urandom_range(63, 0)), 0);
    @(negedge clk);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL rsvd_err: got %b want 1", err); end
    n_vec++; if (in_ready !== 1'b1 || is_start !== 1'b0) begin n_err++; $display("FAIL rsvd_stay_hdr: got ready=%b start=%b want 1/0", in_ready, is_start); end
    @(posedge clk); #1;
    send_byte(8'h80, 0);
    @(negedge clk);
    n_vec++; if (is_start !== 1'b1) begin n_err++; $display("FAIL start_rise: got %b want 1", is_start); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL start_ready: got %b want 0", in_ready); end
    // Offer a full packet's worth of bytes; none may be taken.
    ready_seen = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = (i == 0) ? 8'h00 : 8'($urandom);
      @(negedge clk);
      if (in_ready) ready_seen++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (ready_seen != 0) begin n_err++; $display("FAIL done_ready: got %0d ready cycles want 0", ready_seen); end
    n_vec++; if (is_start !== 1'b1 || err !== 1'b1) begin n_err++; $display("FAIL done_levels: got start=%b err=%b want 1/1", is_start, err); end
    n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL done_writes: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_vec++; if (obs_q[0] !== exp_q[0]) begin n_err++; $display("FAIL pre_start_write: got %h want %h", obs_q[0], exp_q[0]); end
    end
    n_vec++; if (wr_count !== 16'(exp_wr)) begin n_err++; $display("FAIL done_wr_count: got %0d want %0d", wr_count, exp_wr); end
    @(posedge clk); #1;
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    test_reset();
    test_inex_write();
    test_state_write();
    test_stall();
    test_random_packets();
    test_back_to_back();
    test_reset_mid_packet();
    test_reserved_and_start();
    test_reset();  // reset must also leave the terminal state
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
